// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin two-master arbiter in front of the memory-mapped UART slave.
// Optional WAIT-state timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m0_enable_i,
  input  logic        m0_read_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_din_i,
  output logic [31:0] m0_dout_o,
  output logic        m0_ready_o,
  input  logic        m1_enable_i,
  input  logic        m1_read_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_din_i,
  output logic [31:0] m1_dout_o,
  output logic        m1_ready_o,
  output logic        s_enable_o,
  output logic        s_read_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_din_o,
  input  logic [31:0] s_dout_i,
  input  logic        s_ready_i,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      state, state_n;
  logic        last_grant, gnt, sel, any, hit, done_w, tmo, local_w;
  logic [31:0] req_addr, rdata;
  always_comb begin
    any      = m0_enable_i | m1_enable_i;
    sel      = (m0_enable_i && m1_enable_i) ? ~last_grant : m1_enable_i;
    req_addr = sel ? m1_addr_i : m0_addr_i;
    hit      = req_addr[31:4] == 28'h4000000 && req_addr[1:0] == 2'b00;
    local_w  = state == IDLE && any && !hit;
    done_w   = state == WAIT && (s_ready_i || tmo);
    rdata    = s_ready_i ? s_dout_i : ERR_DATA;
    state_n  = state;
    case (state)
      IDLE:  state_n = any ? (hit ? ISSUE : DONE) : IDLE;
      ISSUE: state_n = WAIT;
      WAIT:  state_n = done_w ? DONE : WAIT;
      DONE:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      s_enable_o <= 1'b0;
      s_read_o   <= 1'b0;
      s_addr_o   <= '0;
      s_din_o    <= '0;
      m0_dout_o  <= '0;
      m1_dout_o  <= '0;
      m0_ready_o <= 1'b0;
      m1_ready_o <= 1'b0;
    end else begin
      state      <= state_n;
      s_enable_o <= state == ISSUE;
      m0_ready_o <= (local_w && !sel) || (done_w && !gnt);
      m1_ready_o <= (local_w && sel) || (done_w && gnt);
      if (state == IDLE && any) begin
        gnt      <= sel;
        s_read_o <= sel ? m1_read_i : m0_read_i;
        s_addr_o <= req_addr;
        s_din_o  <= sel ? m1_din_i : m0_din_i;
      end
      if (local_w && sel) m1_dout_o <= '0;
      if (local_w && !sel) m0_dout_o <= '0;
      // writes leave dout alone unless the slave timed out
      if (done_w && (tmo || s_read_o) && gnt) m1_dout_o <= rdata;
      if (done_w && (tmo || s_read_o) && !gnt) m0_dout_o <= rdata;
      if (done_w) last_grant <= gnt;
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wcnt;
  assign tmo = state == WAIT && !s_ready_i && wcnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      wcnt      <= state == ISSUE ? '0 : state == WAIT ? wcnt + 16'd1 : wcnt;
      timeout_o <= timeout_o | tmo;
    end
  end
`else
  assign tmo       = 1'b0 & (TIMEOUT_CYCLES > 0);
  assign timeout_o = 1'b0;
`endif
endmodule
